// File: rtl/note_pkg.sv
// Shared types and constants for the piano round sequencer.
package note_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECORD,
        S_PLAY_OFFER,
        S_PLAY_HOLD
    } state_t;

    typedef struct packed {
        logic [2:0] key;
        logic [2:0] dur;
    } note_t;

    localparam int TICKS_PER_SEC    = 60;
    localparam int DEFAULT_TICK_DIV = 1_666_667;

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_divider
    import note_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic tick_out
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] div_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            div_q <= '0;
        end else if (div_q == LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick_out = (div_q == LAST);

endmodule

// File: rtl/note_round_controller.sv
// Records a round of notes from the key counter and plays them back over valid/ready.
//
// state        | meaning
// S_IDLE       | waiting for start_in (record) or play_in (playback)
// S_RECORD     | capturing notes on each tick until full or stop_in
// S_PLAY_OFFER | offering note[rd_idx] to the tone generator
// S_PLAY_HOLD  | note sounding for dur+1 ticks
module note_round_controller
    import note_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int DEPTH    = 8
) (
    input  logic       clk_in,
    input  logic       rst_in,
    output logic       tick_out,
    input  logic       start_in,
    input  logic       stop_in,
    input  logic       play_in,
    input  logic [7:0] keys_in,
    input  logic [3:0] counter_in,
    input  logic [2:0] key_played_in,
    input  logic [2:0] note_duration_in,
    output logic       note_valid_out,
    input  logic       note_ready_in,
    output logic [2:0] note_key_out,
    output logic [2:0] note_dur_out,
    output logic       playing_out,
    output logic [4:0] notes_stored_out,
    output logic       busy_out,
    output logic       done_out
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);

    logic       tick;
    state_t     state;
    note_t      note_buf [DEPTH];
    logic [4:0] rd_idx;
    logic [3:0] cnt_prev;
    logic [3:0] hold_q;
    logic       note_open;
    logic [2:0] open_key;
    logic [2:0] lat_dur;

    logic       new_note;
    logic       release_ev;
    logic       commit;
    logic       last_commit;
    note_t      commit_note;
    logic [4:0] nxt_idx;
    note_t      nxt_note;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .tick_out(tick)
    );

    assign tick_out = tick;
    assign busy_out = (state != S_IDLE);
    assign nxt_note = note_buf[nxt_idx[IW-1:0]];

    // A counter step outranks a release on the same tick; stop closes out the open note.
    always_comb begin
        new_note   = tick && (counter_in != cnt_prev);
        release_ev = tick && note_open && (keys_in == 8'd0);
        commit     = 1'b0;
        if (state == S_RECORD) begin
            if (stop_in) commit = note_open;
            else         commit = (new_note && note_open) || (!new_note && release_ev);
        end
        commit_note.key = open_key;
        commit_note.dur = (stop_in || new_note) ? lat_dur : note_duration_in;
        last_commit     = commit && (notes_stored_out == LAST_IDX);
        nxt_idx         = rd_idx + 5'd1;
    end

    always_ff @(posedge clk_in) begin
        if (commit) note_buf[notes_stored_out[IW-1:0]] <= commit_note;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= S_IDLE;
            notes_stored_out <= '0;
            rd_idx           <= '0;
            cnt_prev         <= '0;
            hold_q           <= '0;
            note_open        <= 1'b0;
            open_key         <= '0;
            lat_dur          <= '0;
            note_valid_out   <= 1'b0;
            note_key_out     <= '0;
            note_dur_out     <= '0;
            playing_out      <= 1'b0;
            done_out         <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        state            <= S_RECORD;
                        notes_stored_out <= '0;
                        cnt_prev         <= counter_in;
                        note_open        <= 1'b0;
                    end else if (play_in) begin
                        if (notes_stored_out == 5'd0) begin
                            done_out <= 1'b1;
                        end else begin
                            rd_idx         <= '0;
                            state          <= S_PLAY_OFFER;
                            note_valid_out <= 1'b1;
                            note_key_out   <= note_buf[0].key;
                            note_dur_out   <= note_buf[0].dur;
                        end
                    end
                end
                S_RECORD: begin
                    if (commit) notes_stored_out <= notes_stored_out + 5'd1;
                    if (tick)   lat_dur <= note_duration_in;
                    if (stop_in || last_commit) begin
                        done_out  <= 1'b1;
                        state     <= S_IDLE;
                        note_open <= 1'b0;
                    end else if (new_note) begin
                        note_open <= 1'b1;
                        open_key  <= key_played_in;
                        cnt_prev  <= counter_in;
                    end else if (release_ev) begin
                        note_open <= 1'b0;
                    end
                end
                S_PLAY_OFFER: begin
                    if (note_ready_in) begin
                        hold_q         <= {1'b0, note_dur_out} + 4'd1;
                        note_valid_out <= 1'b0;
                        playing_out    <= 1'b1;
                        state          <= S_PLAY_HOLD;
                    end
                end
                S_PLAY_HOLD: begin
                    if (tick) begin
                        hold_q <= hold_q - 4'd1;
                        if (hold_q == 4'd1) begin
                            playing_out <= 1'b0;
                            rd_idx      <= nxt_idx;
                            if (nxt_idx == notes_stored_out) begin
                                done_out     <= 1'b1;
                                state        <= S_IDLE;
                                note_key_out <= '0;
                                note_dur_out <= '0;
                            end else begin
                                state          <= S_PLAY_OFFER;
                                note_valid_out <= 1'b1;
                                note_key_out   <= nxt_note.key;
                                note_dur_out   <= nxt_note.dur;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_round_controller.sv
// Directed bench for note_round_controller with TICK_DIV = 4, DEPTH = 4.
module tb_note_round_controller;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       tick_out;
    logic       start_in, stop_in, play_in;
    logic [7:0] keys_in;
    logic [3:0] counter_in;
    logic [2:0] key_played_in, note_duration_in;
    logic       note_valid_out, note_ready_in;
    logic [2:0] note_key_out, note_dur_out;
    logic       playing_out;
    logic [4:0] notes_stored_out;
    logic       busy_out, done_out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit         sync;
        logic [3:0] cnt;
        logic [2:0] key;
        logic [7:0] keys;
        logic [2:0] dur;
        bit         stop;
        int         exp_stored;
        int         exp_busy;
        int         exp_done;
    } row_t;

    row_t rows[$];

    note_round_controller #(.TICK_DIV(4), .DEPTH(4)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .tick_out        (tick_out),
        .start_in        (start_in),
        .stop_in         (stop_in),
        .play_in         (play_in),
        .keys_in         (keys_in),
        .counter_in      (counter_in),
        .key_played_in   (key_played_in),
        .note_duration_in(note_duration_in),
        .note_valid_out  (note_valid_out),
        .note_ready_in   (note_ready_in),
        .note_key_out    (note_key_out),
        .note_dur_out    (note_dur_out),
        .playing_out     (playing_out),
        .notes_stored_out(notes_stored_out),
        .busy_out        (busy_out),
        .done_out        (done_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic to_tick();
        int n = 0;
        while (tick_out !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("tick_wait", int'(tick_out), 1);
    endtask

    task automatic add(input bit s, input int c, input int k, input int ks, input int d,
                       input bit st, input int es, input int eb, input int ed);
        row_t r;
        r.sync = s; r.cnt = 4'(c); r.key = 3'(k); r.keys = 8'(ks); r.dur = 3'(d);
        r.stop = st; r.exp_stored = es; r.exp_busy = eb; r.exp_done = ed;
        rows.push_back(r);
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (rows[i].sync) to_tick();
            counter_in       = rows[i].cnt;
            key_played_in    = rows[i].key;
            keys_in          = rows[i].keys;
            note_duration_in = rows[i].dur;
            stop_in          = rows[i].stop;
            step();
            stop_in = 1'b0;
            chk($sformatf("row%0d_stored", i), int'(notes_stored_out), rows[i].exp_stored);
            chk($sformatf("row%0d_busy", i), int'(busy_out), rows[i].exp_busy);
            chk($sformatf("row%0d_done", i), int'(done_out), rows[i].exp_done);
        end
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        chk("start_busy", int'(busy_out), 1);
        chk("start_cleared", int'(notes_stored_out), 0);
    endtask

    task automatic count_hold(input string name, input int exp_ticks);
        int ticks = 0;
        int n = 0;
        while (playing_out === 1'b1 && n < 100) begin
            if (tick_out === 1'b1) ticks++;
            step();
            n++;
        end
        chk(name, ticks, exp_ticks);
    endtask

    initial begin
        // Section A (0..9): four notes by counter steps, stop commits the last.
        add(1, 2, 0, 8'h01, 0, 0, 0, 1, 0);
        add(1, 2, 0, 8'h01, 3, 0, 0, 1, 0);
        add(1, 3, 5, 8'h20, 0, 0, 1, 1, 0);
        add(1, 3, 5, 8'h20, 1, 0, 1, 1, 0);
        add(1, 4, 7, 8'h80, 0, 0, 2, 1, 0);
        add(1, 4, 7, 8'h80, 6, 0, 2, 1, 0);
        add(1, 5, 1, 8'h02, 0, 0, 3, 1, 0);
        add(1, 5, 1, 8'h02, 4, 0, 3, 1, 0);
        add(0, 5, 1, 8'h02, 4, 1, 4, 0, 1);
        add(0, 5, 1, 8'h02, 4, 0, 4, 0, 0);
        // Section B (10..15): step and release on one tick, then a real release.
        add(1, 6, 3, 8'h08, 0, 0, 0, 1, 0);
        add(1, 6, 3, 8'h08, 2, 0, 0, 1, 0);
        add(1, 7, 5, 8'h00, 7, 0, 1, 1, 0);
        add(1, 7, 5, 8'h00, 0, 0, 2, 1, 0);
        add(0, 7, 5, 8'h00, 0, 1, 2, 0, 1);
        add(0, 7, 5, 8'h00, 0, 0, 2, 0, 0);
        // Section C (16..21): filling the last entry ends recording on its own.
        add(1, 8, 1, 8'h01, 0, 0, 0, 1, 0);
        add(1, 1, 2, 8'h01, 0, 0, 1, 1, 0);
        add(1, 2, 3, 8'h01, 0, 0, 2, 1, 0);
        add(1, 3, 4, 8'h01, 0, 0, 3, 1, 0);
        add(1, 4, 5, 8'h01, 0, 0, 4, 0, 1);
        add(0, 4, 5, 8'h01, 0, 0, 4, 0, 0);

        rst_in = 1'b0;
        start_in = 1'b0; stop_in = 1'b0; play_in = 1'b0;
        keys_in = 8'h00; counter_in = 4'd0; key_played_in = 3'd0;
        note_duration_in = 3'd0; note_ready_in = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Idle after reset: tick every 4th cycle, everything else quiet.
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("idle_tick_c%0d", c), int'(tick_out), (c % 4 == 0) ? 1 : 0);
            chk($sformatf("idle_quiet_c%0d", c),
                int'({note_valid_out, playing_out, busy_out, done_out, note_key_out,
                      note_dur_out, notes_stored_out}), 0);
            step();
        end

        // Single note recorded through a release.
        pulse_start();
        to_tick();
        counter_in = 4'd1; key_played_in = 3'd3; keys_in = 8'h08; note_duration_in = 3'd0;
        step();
        to_tick(); note_duration_in = 3'd1; step();
        to_tick(); note_duration_in = 3'd2; step();
        chk("rel_before_stored", int'(notes_stored_out), 0);
        to_tick(); keys_in = 8'h00; note_duration_in = 3'd2; step();
        chk("rel_stored", int'(notes_stored_out), 1);
        chk("rel_still_record", int'(busy_out), 1);
        stop_in = 1'b1; step(); stop_in = 1'b0;
        chk("rel_stop_done", int'(done_out), 1);
        chk("rel_stop_busy", int'(busy_out), 0);
        chk("rel_stop_nocommit", int'(notes_stored_out), 1);
        step();
        chk("rel_done_width", int'(done_out), 0);

        keys_in = 8'h01;
        pulse_start();
        run_rows(0, 9);

        pulse_start();
        run_rows(10, 15);

        // Playback of {3,2},{5,0} with a stalled tone generator.
        play_in = 1'b1; step(); play_in = 1'b0;
        chk("offer0_valid", int'(note_valid_out), 1);
        chk("offer0_key", int'(note_key_out), 3);
        chk("offer0_dur", int'(note_dur_out), 2);
        chk("offer0_playing", int'(playing_out), 0);
        for (int s = 0; s < 5; s++) begin
            step();
            chk($sformatf("stall%0d", s),
                int'({note_valid_out, note_key_out, note_dur_out, playing_out}),
                int'({1'b1, 3'd3, 3'd2, 1'b0}));
        end
        note_ready_in = 1'b1; step(); note_ready_in = 1'b0;
        chk("hold0_valid", int'(note_valid_out), 0);
        chk("hold0_playing", int'(playing_out), 1);
        chk("hold0_key", int'(note_key_out), 3);
        chk("hold0_dur", int'(note_dur_out), 2);
        count_hold("hold0_ticks", 3);
        chk("offer1_valid", int'(note_valid_out), 1);
        chk("offer1_key", int'(note_key_out), 5);
        chk("offer1_dur", int'(note_dur_out), 0);
        chk("offer1_busy", int'(busy_out), 1);
        note_ready_in = 1'b1; step(); note_ready_in = 1'b0;
        chk("hold1_key", int'(note_key_out), 5);
        count_hold("hold1_ticks", 1);
        chk("play_done", int'(done_out), 1);
        chk("play_done_busy", int'(busy_out), 0);
        chk("play_done_valid", int'(note_valid_out), 0);
        step();
        chk("play_done_width", int'(done_out), 0);

        // Replay, then reset in the middle of a held note.
        play_in = 1'b1; step(); play_in = 1'b0;
        chk("replay_key", int'(note_key_out), 3);
        note_ready_in = 1'b1; step(); note_ready_in = 1'b0;
        chk("replay_playing", int'(playing_out), 1);
        step(); step();
        #2 rst_in = 1'b0;
        #1;
        chk("rst_outputs",
            int'({tick_out, note_valid_out, note_key_out, note_dur_out, playing_out,
                  notes_stored_out, busy_out, done_out}), 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        step();
        chk("rst_idle", int'(busy_out), 0);

        // Playback request with nothing stored.
        play_in = 1'b1; step(); play_in = 1'b0;
        chk("empty_done", int'(done_out), 1);
        chk("empty_valid", int'(note_valid_out), 0);
        chk("empty_busy", int'(busy_out), 0);
        step();
        chk("empty_done_width", int'(done_out), 0);
        chk("empty_valid_after", int'(note_valid_out), 0);

        counter_in = 4'd7;
        pulse_start();
        run_rows(16, 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/note_round_controller.md
# note_round_controller

Sequencer for one round of the piano game. Divides the system clock into the 60 Hz `trigger` tick that drives the key-press counter. Records up to DEPTH completed notes (key, duration) from that counter's outputs into an internal buffer. Plays the buffer back to the tone generator over a valid/ready handshake.

## Interface
- `TICK_DIV`, default 1666667: clock cycles per tick (100 MHz / 60); legal ≥ 2.
- `DEPTH`, default 8: note buffer entries; legal 1..16.

Ports:
- `clk_in`  in  1  system clock
- `rst_in`  in  1  asynchronous, active-low reset (asserted at 0)
- `tick_out`  out  1  one-cycle pulse every TICK_DIV cycles; wired to the key counter's `trigger`
- `start_in`  in  1  pulse: begin recording (accepted in IDLE only)
- `stop_in`  in  1  pulse: end recording early (RECORD only)
- `play_in`  in  1  pulse: begin playback (accepted in IDLE only)
- `keys_in`  in  8  synchronized key levels
- `counter_in`  in  4  key counter `counter` (1..8, wraps 8→1)
- `key_played_in`  in  3  key counter `key_played`
- `note_duration_in`  in  3  key counter `note_duration` (seconds, saturates at 7)
- `note_valid_out`  out  1  playback note offered
- `note_ready_in`  in  1  tone generator accepts
- `note_key_out`  out  3  key of offered or playing note
- `note_dur_out`  out  3  duration of offered or playing note
- `playing_out`  out  1  high while a note is sounding
- `notes_stored_out`  out  5  entries currently in buffer (0..DEPTH)
- `busy_out`  out  1  state != IDLE
- `done_out`  out  1  one-cycle pulse when RECORD or PLAYBACK ends

## Operation
- States are IDLE, RECORD, PLAY_OFFER and PLAY_HOLD.
- IDLE + `start_in`: go to RECORD.
  - Clear the buffer (`notes_stored_out` ← 0).
  - Baseline `cnt_prev` ← `counter_in`.
  - `note_open` ← 0.
- RECORD events are evaluated only on cycles where `tick_out` = 1.
  - New note: `counter_in` != `cnt_prev`.
    - If `note_open`, commit {open key, last latched duration}.
    - Then open a note with key = `key_played_in`.
    - Set `cnt_prev` ← `counter_in`.
  - Release: `note_open` and `keys_in` == 0. Commit {open key, `note_duration_in`} and set `note_open` ← 0.
  - New note and release on the same tick: new note wins; the release is ignored.
  - While a note is open, latch `note_duration_in` on every tick.
- Commit writes the entry at index `notes_stored_out`, then increments it.
  - Commit of entry DEPTH-1: pulse `done_out` and go to IDLE; the other event on that tick is dropped.
  - `stop_in` in RECORD: commit the open note if there is one, pulse `done_out`, go to IDLE.
- IDLE + `play_in`:
  - If `notes_stored_out` == 0: pulse `done_out` next cycle, stay IDLE.
  - Otherwise: read index ← 0 and go to PLAY_OFFER.
- PLAY_OFFER:
  - `note_valid_out` = 1 with entry[index] on `note_key_out`/`note_dur_out`.
  - Outputs stay stable until `note_valid_out` && `note_ready_in`.
  - On that handshake, load hold ← dur + 1 ticks and go to PLAY_HOLD.
- PLAY_HOLD:
  - `playing_out` = 1; decrement hold on each tick.
  - When hold reaches 0, advance the index.
  - If the index equals `notes_stored_out`, pulse `done_out` and go to IDLE; otherwise go to PLAY_OFFER.
- Buffer contents survive playback; replay is allowed.
- `start_in`, `play_in` and `stop_in` outside their accepting states are ignored.

## Timing
- Reset values: all outputs 0; state IDLE; divider 0; buffer count 0; `note_open` 0.
- Reset assertion mid-operation aborts immediately and asynchronously; buffer contents become undefined, and count is 0.
- Divider:
  - Free-runs in every state.
  - `tick_out` asserts on the cycle the divider equals TICK_DIV-1, then the divider wraps to 0.
  - The first tick comes TICK_DIV cycles after reset release.
- Commit latency: entry written and `notes_stored_out` updated on the clock edge ending the tick cycle; visible the next cycle.
- State changes on `start_in`/`play_in`/`stop_in` take effect at the next edge, so `busy_out` rises 1 cycle after the pulse.
- PLAY_OFFER → PLAY_HOLD: at the handshake edge; `note_valid_out` drops the next cycle.
- PLAY_HOLD length: exactly dur+1 ticks counted from the first tick after entry.
- `note_key_out`/`note_dur_out` hold their value through PLAY_HOLD.
- `done_out` is exactly 1 cycle wide; `busy_out` falls the same cycle `done_out` is high.

## Structure
- Package `note_pkg` contains:
  - `state_t` enum.
  - `note_t` struct {key [2:0], dur [2:0]}.
  - `TICKS_PER_SEC` = 60 and `DEFAULT_TICK_DIV`.
- Sub-module `tick_divider` (parameter TICK_DIV; ports `clk_in`, `rst_in`, `tick_out`) generates the tick.
- Buffer is a DEPTH × `note_t` register array, not BRAM.

## Test plan
Bench uses TICK_DIV = 4 and DEPTH = 4.
- Reset then idle 20 cycles -> `tick_out` pulses at cycles 4, 8, 12, 16, 20 after release; all other outputs stay 0.
- `start_in`; counter 0→1 with key 3 on a tick; hold 2 ticks; `keys_in` → 0 with duration 2 on the next tick -> entry0 = {3,2}, `notes_stored_out` = 1, state still RECORD.
- Four notes with keys 0, 5, 7, 1, each started by a counter step and no releases -> entries 0..2 committed by the following counter steps; `stop_in` commits {1, latched dur}; `notes_stored_out` = 4; `done_out` is one pulse.
- Counter step and release on the same tick -> exactly one commit (previous note); new note is open.
- Playback of {3,2}, {5,0} with `note_ready_in` held low for 5 cycles -> `note_valid_out` holds with key 3 and dur 2; after ready, `playing_out` lasts 3 ticks, then key 5 lasts 1 tick, then `done_out`.
- `play_in` with an empty buffer -> `done_out` the next cycle, no `note_valid_out`.
- Reset asserted during PLAY_HOLD -> all outputs 0 immediately, state IDLE.
